// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-port ALU scheduler.
// State encodings, op codes and the legal-op check.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam int unsigned ALU_DFLT = 2;

  function automatic logic op_legal(input logic [2:0] op);
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      op == OP_AND: ok = 1'b1;
      op == OP_OR:  ok = 1'b1;
      op == OP_ADD: ok = 1'b1;
      op == OP_NOR: ok = 1'b1;
      op == OP_SUB: ok = 1'b1;
      op == OP_SLT: ok = 1'b1;
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_sched_alu.sv
// Combinational ALU shared by both scheduler ports.
// Unknown op codes yield the fixed default value.
module alu_sched_alu
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = WIDTH'(ALU_DFLT);
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_ADD:  y = a + b;
      OP_NOR:  y = ~(a | b);
      OP_SUB:  y = a - b;
      OP_SLT:  y = WIDTH'(a < b);
      default: y = WIDTH'(ALU_DFLT);
    endcase
  end

endmodule

// File: rtl/alu_sched.sv
// Two-port round-robin scheduler around a single ALU.
// IDLE grants and latches, EXEC registers the result, RESP waits.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_z,
  output logic             rsp_err,
  output logic             busy,
  output logic [15:0]      op_count
);

  state_t           state;
  logic             ptr;
  logic             owner;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] y;
  logic [15:0]      cnt_q;
  logic             gnt;
  logic             take;
  logic             done;

  alu_sched_alu #(.WIDTH(WIDTH)) u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (y)
  );

  // Pointer only breaks ties; a lone requester always wins.
  assign gnt  = (&req_valid) ? ptr : req_valid[1];
  assign take = (state == S_IDLE) && (|req_valid);
  assign done = (state == S_RESP) && rsp_ready[owner];

  assign req_ready = take ? {gnt, ~gnt} : 2'b00;
  assign busy      = (state != S_IDLE);
  assign op_count  = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      op_q      <= 3'b000;
      a_q       <= '0;
      b_q       <= '0;
      rsp_valid <= 2'b00;
      rsp_y     <= '0;
      rsp_z     <= 1'b0;
      rsp_err   <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            owner <= gnt;
            op_q  <= gnt ? req_op1 : req_op0;
            a_q   <= gnt ? req_a1 : req_a0;
            b_q   <= gnt ? req_b1 : req_b0;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_y     <= y;
          rsp_z     <= (y == '0);
          rsp_err   <= ~op_legal(op_q);
          rsp_valid <= {owner, ~owner};
          state     <= S_RESP;
        end
        S_RESP: begin
          if (done) begin
            rsp_valid <= 2'b00;
            cnt_q     <= cnt_q + 16'd1;
            ptr       <= ~owner;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
